// File: rtl/tdes_chain_engine.sv
// -----------------------------------------------------------------------------
// tdes_chain_engine
//
// Multi-channel ECB/CBC chaining controller wrapped around a fixed-latency,
// fully pipelined 3DES core. Each channel owns a chain register. A tag
// pipeline runs alongside the core and carries per-block context, so the
// matching core result can be finished (CBC XOR, chain update) and queued in
// an output FIFO in issue order. Admission is credit-based: blocks in the
// core plus entries in the FIFO never exceed OUT_DEPTH, so results are never
// dropped under backpressure.
//
// Ports
//   i_clk, i_n_rst                 clock, asynchronous active-low reset
//   i_key1/2/3                     cipher keys (stable while blocks in flight)
//   i_in_valid/o_in_ready          input handshake
//   i_in_data/i_in_ch              input block and channel id
//   i_in_decrypt/i_in_cbc          direction and chaining mode of the block
//   i_iv_load/i_iv_ch/i_iv_data    chain register (IV) write port
//   o_core_in_valid/_data          block issued to the core
//   o_core_decrypt, o_core_k1/2/3  core direction and keys in pass order
//   i_core_out_valid/_data         core result (valid is cross-checked only)
//   o_out_valid/i_out_ready        output handshake
//   o_out_data/o_out_ch            result block and its channel
// -----------------------------------------------------------------------------
module tdes_chain_engine #(
  parameter int NCH       = 4,
  parameter int CORE_LAT  = 48,
  parameter int OUT_DEPTH = 4,
  parameter int KEYING    = 3,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          i_clk,
  input  logic          i_n_rst,
  input  logic [63:0]   i_key1,
  input  logic [63:0]   i_key2,
  input  logic [63:0]   i_key3,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [63:0]   i_in_data,
  input  logic [CW-1:0] i_in_ch,
  input  logic          i_in_decrypt,
  input  logic          i_in_cbc,
  input  logic          i_iv_load,
  input  logic [CW-1:0] i_iv_ch,
  input  logic [63:0]   i_iv_data,
  output logic          o_core_in_valid,
  output logic [63:0]   o_core_in_data,
  output logic          o_core_decrypt,
  output logic [63:0]   o_core_k1,
  output logic [63:0]   o_core_k2,
  output logic [63:0]   o_core_k3,
  input  logic          i_core_out_valid,
  input  logic [63:0]   i_core_out_data,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [63:0]   o_out_data,
  output logic [CW-1:0] o_out_ch
);

  localparam int DATA_W = 64;
  localparam int NSLOT  = 1 << CW;
  localparam int PW     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNTW   = $clog2(OUT_DEPTH + 1);
  localparam int SUMW   = CNTW + 1;
  localparam int LAST   = CORE_LAT - 1;

  // Per-channel chaining state
  logic [DATA_W-1:0] r_chain [NSLOT];
  logic [NSLOT-1:0]  r_busy;

  // Tag pipeline, one entry per core stage
  logic              r_tag_vld [CORE_LAT];
  logic [CW-1:0]     r_tag_ch  [CORE_LAT];
  logic              r_tag_cbc [CORE_LAT];
  logic              r_tag_dec [CORE_LAT];
  logic [DATA_W-1:0] r_tag_xor [CORE_LAT];

  // Output FIFO and credit counters
  logic [DATA_W-1:0] r_fifo_data [OUT_DEPTH];
  logic [CW-1:0]     r_fifo_ch   [OUT_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CNTW-1:0]   r_fifo_cnt;
  logic [CNTW-1:0]   r_inflight;

  logic              w_credit_ok;
  logic              w_iv_clash;
  logic              w_accept;
  logic              w_cbc_enc;
  logic              w_cbc_dec;
  logic [DATA_W-1:0] w_k3;
  logic              w_ret;
  logic              w_ret_enc;
  logic [CW-1:0]     w_ret_ch;
  logic [DATA_W-1:0] w_result;
  logic              w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---- stage 0: admission and issue to the core --------------------------
  assign w_credit_ok = (SUMW'(r_inflight) + SUMW'(r_fifo_cnt)) < SUMW'(OUT_DEPTH);
  assign w_iv_clash  = i_iv_load && (i_iv_ch == i_in_ch);
  assign o_in_ready  = i_n_rst && w_credit_ok && !r_busy[i_in_ch] && !w_iv_clash;
  assign w_accept    = i_in_valid && o_in_ready;
  assign w_cbc_enc   = i_in_cbc && !i_in_decrypt;
  assign w_cbc_dec   = i_in_cbc && i_in_decrypt;
  assign w_k3        = (KEYING == 2) ? i_key1 : i_key3;

  always_comb begin
    o_core_in_valid = w_accept;
    o_core_decrypt  = w_accept && i_in_decrypt;
    o_core_in_data  = '0;
    o_core_k1       = '0;
    o_core_k2       = '0;
    o_core_k3       = '0;
    if (w_accept) begin
      o_core_in_data = w_cbc_enc ? (i_in_data ^ r_chain[i_in_ch]) : i_in_data;
    end
    // Decrypt runs the key schedule in reverse pass order
    if (i_n_rst) begin
      o_core_k1 = i_in_decrypt ? w_k3   : i_key1;
      o_core_k2 = i_key2;
      o_core_k3 = i_in_decrypt ? i_key1 : w_k3;
    end
  end

  // ---- stage CORE_LAT: result return from the core -----------------------
  assign w_ret     = r_tag_vld[LAST];
  assign w_ret_ch  = r_tag_ch[LAST];
  assign w_ret_enc = w_ret && r_tag_cbc[LAST] && !r_tag_dec[LAST];
  // Xor value is zero for everything but CBC decrypt, so one XOR serves all
  assign w_result  = i_core_out_data ^ r_tag_xor[LAST];

  // ---- output stage: FIFO head ---------------------------------------------
  assign o_out_valid = (r_fifo_cnt != '0);
  assign o_out_data  = r_fifo_data[r_rd_ptr];
  assign o_out_ch    = r_fifo_ch[r_rd_ptr];
  assign w_pop       = o_out_valid && i_out_ready;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      for (int i = 0; i < NSLOT; i++) r_chain[i] <= '0;
      r_busy <= '0;
      for (int s = 0; s < CORE_LAT; s++) begin
        r_tag_vld[s] <= 1'b0;
        r_tag_ch[s]  <= '0;
        r_tag_cbc[s] <= 1'b0;
        r_tag_dec[s] <= 1'b0;
        r_tag_xor[s] <= '0;
      end
      for (int f = 0; f < OUT_DEPTH; f++) begin
        r_fifo_data[f] <= '0;
        r_fifo_ch[f]   <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_inflight <= '0;
    end else begin
      // A CBC-encrypt return outranks an IV load on the same channel
      for (int i = 0; i < NSLOT; i++) begin
        if (w_ret_enc && (w_ret_ch == CW'(i))) begin
          r_chain[i] <= i_core_out_data;
          r_busy[i]  <= 1'b0;
        end else if (w_accept && w_cbc_dec && (i_in_ch == CW'(i))) begin
          r_chain[i] <= i_in_data;
        end else if (i_iv_load && (i_iv_ch == CW'(i))) begin
          r_chain[i] <= i_iv_data;
        end
        if (w_accept && w_cbc_enc && (i_in_ch == CW'(i))) r_busy[i] <= 1'b1;
      end

      r_tag_vld[0] <= w_accept;
      r_tag_ch[0]  <= i_in_ch;
      r_tag_cbc[0] <= i_in_cbc;
      r_tag_dec[0] <= i_in_decrypt;
      r_tag_xor[0] <= (w_accept && w_cbc_dec) ? r_chain[i_in_ch] : '0;
      for (int s = 1; s < CORE_LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_ch[s]  <= r_tag_ch[s-1];
        r_tag_cbc[s] <= r_tag_cbc[s-1];
        r_tag_dec[s] <= r_tag_dec[s-1];
        r_tag_xor[s] <= r_tag_xor[s-1];
      end

      if (w_ret) begin
        r_fifo_data[r_wr_ptr] <= w_result;
        r_fifo_ch[r_wr_ptr]   <= w_ret_ch;
        r_wr_ptr              <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);

      r_fifo_cnt <= r_fifo_cnt + CNTW'(w_ret) - CNTW'(w_pop);
      r_inflight <= r_inflight + CNTW'(w_accept) - CNTW'(w_ret);
    end
  end

  // The tag is authoritative; a disagreeing core valid means a broken core
  a_tag_matches_core: assert property (
    @(posedge i_clk) disable iff (!i_n_rst) r_tag_vld[LAST] == i_core_out_valid);

endmodule

// File: tb/tb_tdes_chain_engine.sv
module tb_tdes_chain_engine;
  localparam int NCH = 2, CORE_LAT = 4, OUT_DEPTH = 4, CW = 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] key1, key2, key3, in_data, iv_data;
  logic in_valid, in_decrypt, in_cbc, iv_load, out_ready;
  logic [CW-1:0] in_ch, iv_ch;

  // DUT a: three-key; DUT b: two-key, same stimulus
  logic a_in_ready, a_civ, a_cdec, a_cov, a_out_valid;
  logic [63:0] a_cid, a_ck1, a_ck2, a_ck3, a_cod, a_out_data;
  logic [CW-1:0] a_out_ch;
  logic b_in_ready, b_civ, b_cdec, b_cov, b_out_valid;
  logic [63:0] b_cid, b_ck1, b_ck2, b_ck3, b_cod, b_out_data;
  logic [CW-1:0] b_out_ch;

  tdes_chain_engine #(.NCH(NCH), .CORE_LAT(CORE_LAT), .OUT_DEPTH(OUT_DEPTH), .KEYING(3)) dut_a (
    .i_clk(clk), .i_n_rst(n_rst), .i_key1(key1), .i_key2(key2), .i_key3(key3),
    .i_in_valid(in_valid), .o_in_ready(a_in_ready), .i_in_data(in_data), .i_in_ch(in_ch),
    .i_in_decrypt(in_decrypt), .i_in_cbc(in_cbc), .i_iv_load(iv_load), .i_iv_ch(iv_ch),
    .i_iv_data(iv_data), .o_core_in_valid(a_civ), .o_core_in_data(a_cid),
    .o_core_decrypt(a_cdec), .o_core_k1(a_ck1), .o_core_k2(a_ck2), .o_core_k3(a_ck3),
    .i_core_out_valid(a_cov), .i_core_out_data(a_cod), .o_out_valid(a_out_valid),
    .i_out_ready(out_ready), .o_out_data(a_out_data), .o_out_ch(a_out_ch));

  tdes_chain_engine #(.NCH(NCH), .CORE_LAT(CORE_LAT), .OUT_DEPTH(OUT_DEPTH), .KEYING(2)) dut_b (
    .i_clk(clk), .i_n_rst(n_rst), .i_key1(key1), .i_key2(key2), .i_key3(key3),
    .i_in_valid(in_valid), .o_in_ready(b_in_ready), .i_in_data(in_data), .i_in_ch(in_ch),
    .i_in_decrypt(in_decrypt), .i_in_cbc(in_cbc), .i_iv_load(iv_load), .i_iv_ch(iv_ch),
    .i_iv_data(iv_data), .o_core_in_valid(b_civ), .o_core_in_data(b_cid),
    .o_core_decrypt(b_cdec), .o_core_k1(b_ck1), .o_core_k2(b_ck2), .o_core_k3(b_ck3),
    .i_core_out_valid(b_cov), .i_core_out_data(b_cod), .o_out_valid(b_out_valid),
    .i_out_ready(out_ready), .o_out_data(b_out_data), .o_out_ch(b_out_ch));

  // Stub cores: out = in ^ k1, CORE_LAT cycles later, reset shared
  logic        a_sv [CORE_LAT];
  logic [63:0] a_sd [CORE_LAT];
  logic        b_sv [CORE_LAT];
  logic [63:0] b_sd [CORE_LAT];
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int s = 0; s < CORE_LAT; s++) begin
        a_sv[s] <= 1'b0; a_sd[s] <= '0; b_sv[s] <= 1'b0; b_sd[s] <= '0;
      end
    end else begin
      a_sv[0] <= a_civ; a_sd[0] <= a_cid ^ a_ck1;
      b_sv[0] <= b_civ; b_sd[0] <= b_cid ^ b_ck1;
      for (int s = 1; s < CORE_LAT; s++) begin
        a_sv[s] <= a_sv[s-1]; a_sd[s] <= a_sd[s-1];
        b_sv[s] <= b_sv[s-1]; b_sd[s] <= b_sd[s-1];
      end
    end
  end
  assign a_cov = a_sv[CORE_LAT-1];
  assign a_cod = a_sd[CORE_LAT-1];
  assign b_cov = b_sv[CORE_LAT-1];
  assign b_cod = b_sd[CORE_LAT-1];

  typedef struct {
    logic [63:0]   da;
    logic [63:0]   db;
    logic [CW-1:0] ch;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [CW-1:0] ch;
    logic          dec;
    logic [63:0]   data;
    logic [63:0]   k1;
    logic [63:0]   k3;
    logic [63:0]   ea;
    logic [63:0]   eb;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_pop_cyc = -1;
  int pops = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Output monitor / scoreboard pop
  always @(negedge clk) begin : mon
    exp_t e;
    if (n_rst && a_out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", a_out_data);
      end else begin
        e = sb.pop_front();
        check64("out_data_k3", a_out_data, e.da);
        check64("out_data_k2", b_out_data, e.db);
        check64("out_ch", {63'd0, a_out_ch}, {63'd0, e.ch});
        check64("out_valid_k2", {63'd0, b_out_valid}, 64'd1);
      end
      pops++;
      last_pop_cyc = cyc;
    end
  end

  // One cycle of offering; pushes the expectation if the block is taken
  task automatic offer(input logic [CW-1:0] ch, input logic dec, input logic cbc,
                       input logic [63:0] d, input logic [63:0] ea, input logic [63:0] eb,
                       output logic acc);
    exp_t e;
    in_valid = 1'b1; in_ch = ch; in_decrypt = dec; in_cbc = cbc; in_data = d;
    @(negedge clk);
    acc = a_in_ready;
    if (acc) begin
      e.da = ea; e.db = eb; e.ch = ch;
      sb.push_back(e);
      acc_cyc = cyc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [CW-1:0] ch, input logic dec, input logic cbc,
                      input logic [63:0] d, input logic [63:0] ea, input logic [63:0] eb,
                      output int acyc);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      offer(ch, dec, cbc, d, ea, eb, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=refused required=accepted data=%h", d);
    end
    acyc = acc_cyc;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic load_iv(input logic [CW-1:0] ch, input logic [63:0] v);
    iv_load = 1'b1; iv_ch = ch; iv_data = v;
    @(posedge clk); #1;
    iv_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int acyc, acyc2, nacc, pops0;
    logic acc;

    vecs[0] = '{1'b0, 1'b0, 64'h00000000000000FF, 64'h1111111111111111, 64'h0,
                64'h11111111111111EE, 64'h11111111111111EE};
    vecs[1] = '{1'b0, 1'b1, 64'h00000000000000FF, 64'h1111111111111111, 64'h3333333333333333,
                64'h33333333333333CC, 64'h11111111111111EE};
    vecs[2] = '{1'b1, 1'b0, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 64'h0,
                64'hFEDCBA9876543210, 64'hFEDCBA9876543210};
    vecs[3] = '{1'b1, 1'b1, 64'h0, 64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0,
                64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F};
    vecs[4] = '{1'b0, 1'b1, 64'hFFFFFFFF00000000, 64'h0, 64'h1234567812345678,
                64'hEDCBA98712345678, 64'hFFFFFFFF00000000};

    key1 = 64'h1111111111111111; key2 = {$urandom, $urandom}; key3 = 64'h3333333333333333;
    in_valid = 1'b1; in_data = 64'hDEADBEEFDEADBEEF; in_ch = '0; in_decrypt = 1'b0; in_cbc = 1'b0;
    iv_load = 1'b0; iv_ch = '0; iv_data = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check64("rst_in_ready", {63'd0, a_in_ready}, 64'd0);
    check64("rst_core_in_valid", {63'd0, a_civ}, 64'd0);
    check64("rst_core_in_data", a_cid, 64'd0);
    check64("rst_core_k1", a_ck1, 64'd0);
    check64("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    check64("rst_out_data", a_out_data, 64'd0);
    check64("rst_out_ch", {63'd0, a_out_ch}, 64'd0);
    in_valid = 1'b0;
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Single-block ECB vectors, both keyings, with latency check
    for (int i = 0; i < 5; i++) begin
      key1 = vecs[i].k1; key3 = vecs[i].k3;
      send(vecs[i].ch, vecs[i].dec, 1'b0, vecs[i].data, vecs[i].ea, vecs[i].eb, acyc);
      wait_drain();
      check64("ecb_latency", 64'(last_pop_cyc - acyc), 64'd5);
    end

    // CBC encrypt on ch0: busy window, ch1 bypasses it
    key1 = 64'h1111111111111111; key3 = 64'h0;
    load_iv(1'b0, 64'hAAAAAAAAAAAAAAAA);
    send(1'b0, 1'b0, 1'b1, 64'h0, 64'hBBBBBBBBBBBBBBBB, 64'hBBBBBBBBBBBBBBBB, acyc);
    offer(1'b0, 1'b0, 1'b1, 64'h0, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, acc);
    check64("cbc_enc_busy", {63'd0, acc}, 64'd0);
    offer(1'b1, 1'b0, 1'b0, 64'h5, 64'h1111111111111114, 64'h1111111111111114, acc);
    check64("other_ch_accept", {63'd0, acc}, 64'd1);
    send(1'b0, 1'b0, 1'b1, 64'h0, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, acyc2);
    check64("cbc_enc_spacing", 64'(acyc2 - acyc), 64'd5);
    wait_drain();

    // CBC decrypt on ch1, back-to-back
    key1 = 64'h0; key3 = 64'h0;
    load_iv(1'b1, 64'h0);
    offer(1'b1, 1'b1, 1'b1, 64'd1, 64'd1, 64'd1, acc);
    check64("cbc_dec_b2b_0", {63'd0, acc}, 64'd1);
    offer(1'b1, 1'b1, 1'b1, 64'd2, 64'd3, 64'd3, acc);
    check64("cbc_dec_b2b_1", {63'd0, acc}, 64'd1);
    offer(1'b1, 1'b1, 1'b1, 64'd3, 64'd1, 64'd1, acc);
    check64("cbc_dec_b2b_2", {63'd0, acc}, 64'd1);
    offer(1'b1, 1'b1, 1'b1, 64'd4, 64'd7, 64'd7, acc);
    check64("cbc_dec_b2b_3", {63'd0, acc}, 64'd1);
    wait_drain();

    // Backpressure: credits cap acceptance at OUT_DEPTH
    key1 = 64'h0123456701234567;
    out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      offer(CW'(i % 2), 1'b0, 1'b0, 64'(i), 64'(i) ^ key1, 64'(i) ^ key1, acc);
      if (acc) nacc++;
    end
    check64("bp_accept_count", 64'(nacc), 64'd4);
    @(negedge clk);
    check64("bp_in_ready_full", {63'd0, a_in_ready}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check64("credit_pop_cycle", {63'd0, a_in_ready}, 64'd0);
    @(negedge clk);
    check64("credit_next_cycle", {63'd0, a_in_ready}, 64'd1);
    @(posedge clk); #1;
    wait_drain();

    // Reset with one result queued, three in flight, ch0 busy
    key1 = 64'h5555555555555555;
    out_ready = 1'b0;
    send(1'b1, 1'b0, 1'b0, 64'h1, 64'h5555555555555554, 64'h5555555555555554, acyc);
    repeat (6) @(posedge clk); #1;
    check64("pre_reset_out_valid", {63'd0, a_out_valid}, 64'd1);
    send(1'b0, 1'b0, 1'b1, 64'h2, 64'h0, 64'h0, acyc);
    send(1'b1, 1'b0, 1'b0, 64'h3, 64'h0, 64'h0, acyc);
    send(1'b1, 1'b0, 1'b0, 64'h4, 64'h0, 64'h0, acyc);
    in_valid = 1'b1; in_ch = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    check64("async_rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    check64("async_rst_in_ready", {63'd0, a_in_ready}, 64'd0);
    check64("async_rst_out_data", a_out_data, 64'd0);
    in_valid = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    n_rst = 1'b1;
    out_ready = 1'b1;
    pops0 = pops;
    repeat (10) @(posedge clk); #1;
    check64("no_stale_outputs", 64'(pops - pops0), 64'd0);
    key1 = 64'h0BADF00D0BADF00D;
    send(1'b0, 1'b0, 1'b1, 64'h0, 64'h0BADF00D0BADF00D, 64'h0BADF00D0BADF00D, acyc);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
